// File: rtl/counter_pkg.sv
// Shared limits and digit-width helper for the cascaded mod-N counter.
package counter_pkg;

  localparam int unsigned MOD_MIN    = 2;
  localparam int unsigned MOD_MAX    = 16;
  localparam int unsigned DIGITS_MIN = 1;
  localparam int unsigned DIGITS_MAX = 8;

  function automatic int unsigned digit_width(input int unsigned modulus);
    return $clog2(modulus);
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One mod-MOD digit: saturating parallel load, then enabled up/down step.
module mod_n_digit
  import counter_pkg::*;
#(
  parameter int unsigned MOD = 10,
  parameter int unsigned W   = digit_width(MOD)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         step,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         at_max,
  output logic         at_min
);

  localparam logic [W-1:0] MAX_V = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] load_v;

  assign at_max = (cnt_q == MAX_V);
  assign at_min = (cnt_q == '0);
  assign q      = cnt_q;

  always_comb begin
    // Out-of-range load values clamp to the top digit value.
    load_v = ({1'b0, d} >= (W + 1)'(MOD)) ? MAX_V : d;
    cnt_d  = cnt_q;
    if (load) begin
      cnt_d = load_v;
    end else if (step) begin
      if (up) cnt_d = at_max ? '0    : cnt_q + 1'b1;
      else    cnt_d = at_min ? MAX_V : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mod_n_counter.sv
// Synchronous cascade of mod-MOD digits with terminal count and registered wrap pulse.
module mod_n_counter
  import counter_pkg::*;
#(
  parameter  int unsigned MOD    = 10,
  parameter  int unsigned DIGITS = 4,
  localparam int unsigned W      = digit_width(MOD)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [DIGITS*W-1:0] din,
  output logic [DIGITS*W-1:0] q,
  output logic              tc,
  output logic              wrap
);

  logic [DIGITS-1:0] at_max, at_min, step;
  logic              wrap_d, wrap_q;

  // Each digit steps when every lower digit sits at its rollover value.
  always_comb begin
    logic lo_max, lo_min;
    lo_max = 1'b1;
    lo_min = 1'b1;
    step   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      step[i] = en & (up ? lo_max : lo_min);
      lo_max  = lo_max & at_max[i];
      lo_min  = lo_min & at_min[i];
    end
  end

  assign tc     = en & ~load & (up ? &at_max : &at_min);
  assign wrap_d = tc;
  assign wrap   = wrap_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) wrap_q <= 1'b0;
    else      wrap_q <= wrap_d;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    mod_n_digit #(
      .MOD (MOD),
      .W   (W)
    ) u_digit (
      .clk    (clk),
      .clr    (clr),
      .step   (step[g]),
      .up     (up),
      .load   (load),
      .d      (din[g*W +: W]),
      .q      (q[g*W +: W]),
      .at_max (at_max[g]),
      .at_min (at_min[g])
    );
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: value-level reference model feeding an expected-result queue.
module tb_mod_n_counter;

  typedef struct {
    string       tag;
    logic        inst_b;
    logic [31:0] q;
    logic        wrap;
  } exp_t;

  exp_t sbq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        clk = 1'b0;
  logic        clr;
  logic        en_a, up_a, load_a;
  logic [15:0] din_a, q_a;
  logic        tc_a, wrap_a;
  logic        en_b, up_b, load_b;
  logic [5:0]  din_b, q_b;
  logic        tc_b, wrap_b;

  int val_a = 0;
  int val_b = 0;
  int wrap_cnt_b = 0;

  always #5 clk = ~clk;

  mod_n_counter u_dut_a (
    .clk(clk), .clr(clr), .en(en_a), .up(up_a), .load(load_a),
    .din(din_a), .q(q_a), .tc(tc_a), .wrap(wrap_a)
  );

  mod_n_counter #(.MOD(6), .DIGITS(2)) u_dut_b (
    .clk(clk), .clr(clr), .en(en_b), .up(up_b), .load(load_b),
    .din(din_b), .q(q_b), .tc(tc_b), .wrap(wrap_b)
  );

  function automatic logic [31:0] pack(input int v, input int m, input int nd, input int w);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r = r | (32'(x % m) << (i * w));
      x = x / m;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [31:0] d, input int m, input int nd, input int w);
    int v, p, dig;
    v = 0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      dig = int'((d >> (i * w)) & ((32'd1 << w) - 1));
      if (dig >= m) dig = m - 1;
      v = v + dig * p;
      p = p * m;
    end
    return v;
  endfunction

  function automatic int pow_i(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive, check tc, predict, then compare after the rising edge.
  task automatic step_a(input logic e, input logic u, input logic l, input logic [15:0] d,
                        input string tag);
    int n;
    logic etc;
    exp_t x;
    n = pow_i(10, 4);
    en_a = e; up_a = u; load_a = l; din_a = d;
    #1;
    etc = e & ~l & (u ? (val_a == n - 1) : (val_a == 0));
    check({tag, "_tc"}, 32'(tc_a), 32'(etc));
    if (l)      val_a = clamp_val(32'(d), 10, 4, 4);
    else if (e) val_a = u ? (val_a + 1) % n : (val_a + n - 1) % n;
    sbq.push_back('{tag, 1'b0, pack(val_a, 10, 4, 4), etc});
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    check({x.tag, "_q"}, 32'(q_a), x.q);
    check({x.tag, "_wrap"}, 32'(wrap_a), 32'(x.wrap));
    @(negedge clk);
  endtask

  task automatic step_b(input logic e, input logic u, input string tag);
    int n;
    logic etc;
    exp_t x;
    n = 36;
    en_b = e; up_b = u; load_b = 1'b0; din_b = '0;
    #1;
    etc = e & (u ? (val_b == n - 1) : (val_b == 0));
    if (e) val_b = u ? (val_b + 1) % n : (val_b + n - 1) % n;
    sbq.push_back('{tag, 1'b1, pack(val_b, 6, 2, 3), etc});
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    check({x.tag, "_q"}, 32'(q_b), x.q);
    check({x.tag, "_wrap"}, 32'(wrap_b), 32'(x.wrap));
    check({x.tag, "_d0rng"}, 32'(q_b[2:0] < 3'd6), 32'd1);
    check({x.tag, "_d1rng"}, 32'(q_b[5:3] < 3'd6), 32'd1);
    if (wrap_b) wrap_cnt_b++;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0;
    en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; din_a = '0;
    en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; din_b = '0;
    #2;
    check("rst_q", 32'(q_a), 32'h0);
    check("rst_wrap", 32'(wrap_a), 32'h0);
    check("rst_tc_idle", 32'(tc_a), 32'h0);
    en_a = 1'b1; up_a = 1'b0;
    #1;
    check("rst_tc_down", 32'(tc_a), 32'h1);
    en_a = 1'b0;
    @(negedge clk);
    clr = 1'b1;

    for (int i = 0; i < 10; i++) step_a(1'b1, 1'b1, 1'b0, 16'h0, $sformatf("up%0d", i));

    step_a(1'b0, 1'b1, 1'b1, 16'h9999, "ld9999");
    step_a(1'b1, 1'b1, 1'b0, 16'h0, "wrap_up");
    step_a(1'b0, 1'b1, 1'b0, 16'h0, "wrap_end");

    step_a(1'b0, 1'b0, 1'b1, 16'h0100, "ld0100");
    step_a(1'b1, 1'b0, 1'b0, 16'h0, "borrow");

    step_a(1'b1, 1'b1, 1'b1, 16'hF3A2, "ldsat");

    step_a(1'b0, 1'b1, 1'b1, 16'h0000, "ld0000");
    step_a(1'b1, 1'b0, 1'b0, 16'h0, "wrap_dn");
    step_a(1'b1, 1'b1, 1'b0, 16'h0, "dir_up");
    step_a(1'b1, 1'b0, 1'b0, 16'h0, "dir_dn");
    step_a(1'b1, 1'b0, 1'b0, 16'h0, "dir_dn2");
    step_a(1'b0, 1'b0, 1'b0, 16'h0, "hold");

    step_a(1'b0, 1'b1, 1'b1, 16'h0457, "ld0457");
    step_a(1'b1, 1'b1, 1'b0, 16'h0, "cnt0458");
    en_a = 1'b1; up_a = 1'b1; load_a = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    check("clr_async_q", 32'(q_a), 32'h0);
    check("clr_async_wrap", 32'(wrap_a), 32'h0);
    load_a = 1'b1; din_a = 16'h1234;
    @(posedge clk);
    #1;
    check("clr_hold_q", 32'(q_a), 32'h0);
    check("clr_hold_wrap", 32'(wrap_a), 32'h0);
    val_a = 0;
    load_a = 1'b0; en_a = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    step_a(1'b1, 1'b1, 1'b0, 16'h0, "first_after_clr");

    for (int i = 0; i < 36; i++) step_b(1'b1, 1'b1, $sformatf("b_up%0d", i));
    check("b_wrap_count", 32'(wrap_cnt_b), 32'd1);
    check("b_final_q", 32'(q_b), 32'h0);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
